// File: rtl/div_fixed_complex_seq.sv
// Sequential complex fixed-point divider y = a*conj(b)/|b|^2 on signed QI.QF operands.
// Optional round-half-away-from-zero under `define DIV_FIXED_COMPLEX_ROUND_EN.
module div_fixed_complex_seq #(
  parameter int unsigned QI = 3,
  parameter int unsigned QF = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [QI+QF-1:0] a_Re,
  input  logic signed [QI+QF-1:0] a_Im,
  input  logic signed [QI+QF-1:0] b_Re,
  input  logic signed [QI+QF-1:0] b_Im,
  output logic                    busy,
  output logic                    done,
  output logic signed [QI+QF-1:0] y_Re,
  output logic signed [QI+QF-1:0] y_Im,
  output logic                    overflow,
  output logic                    div_by_zero
);
  localparam int unsigned W  = QI + QF;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned NW = 2 * W + 1;
  localparam int unsigned D  = 2 * W + QF;
  localparam int unsigned RW = 2 * W + 2;
  localparam int unsigned CW = $clog2(D);
  localparam logic [D:0]  POS_MAX = (D+1)'((2 ** (W - 1)) - 1);
  localparam logic [D:0]  NEG_MAX = (D+1)'(2 ** (W - 1));

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;

  state_t state, state_nx;

  logic signed [W-1:0] ar, ai, br, bi;
  logic [D-1:0]        dvd_re, dvd_im;
  logic [NW-1:0]       rem_re, rem_im;
  logic [NW-1:0]       den;
  logic                sgn_re, sgn_im;
  logic [CW-1:0]       cnt;

  logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri, p_brr, p_bii;
  logic signed [NW-1:0] num_re, num_im;
  logic [NW-1:0]        den_c;
  logic [PW-1:0]        mag_re, mag_im;
  logic [RW-1:0]        rsh_re, rsh_im;
  logic                 ge_re, ge_im;
  logic [NW-1:0]        rem_re_nx, rem_im_nx;
  logic [D-1:0]         dvd_re_nx, dvd_im_nx;
  logic                 rnd_re, rnd_im;
  logic [D:0]           mq_re, mq_im;
  logic [W:0]           res_re, res_im;
  logic                 last_step;

  // {saturated, value}: clamp a magnitude to the signed W-bit range given its sign
  function automatic logic [W:0] saturate(input logic [D:0] mag, input logic neg);
    logic [W:0] r;
    r = '0;
    if (!neg) begin
      if (mag > POS_MAX) r = {1'b1, 1'b0, {(W-1){1'b1}}};
      else               r = {1'b0, mag[W-1:0]};
    end else begin
      if (mag > NEG_MAX) r = {1'b1, 1'b1, {(W-1){1'b0}}};
      else               r = {1'b0, W'(-mag[W-1:0])};
    end
    return r;
  endfunction

  // Full-precision numerator and |b|^2 from the captured operands
  always_comb begin
    p_rr   = PW'(ar) * PW'(br);
    p_ii   = PW'(ai) * PW'(bi);
    p_ir   = PW'(ai) * PW'(br);
    p_ri   = PW'(ar) * PW'(bi);
    p_brr  = PW'(br) * PW'(br);
    p_bii  = PW'(bi) * PW'(bi);
    num_re = NW'(p_rr) + NW'(p_ii);
    num_im = NW'(p_ir) - NW'(p_ri);
    den_c  = NW'($unsigned(p_brr)) + NW'($unsigned(p_bii));
    mag_re = num_re[NW-1] ? PW'(-num_re) : PW'(num_re);
    mag_im = num_im[NW-1] ? PW'(-num_im) : PW'(num_im);
  end

  // One restoring step per component; the dividend register shifts quotient bits in
  always_comb begin
    rsh_re    = {rem_re, dvd_re[D-1]};
    rsh_im    = {rem_im, dvd_im[D-1]};
    ge_re     = rsh_re >= RW'(den);
    ge_im     = rsh_im >= RW'(den);
    rem_re_nx = ge_re ? NW'(rsh_re - RW'(den)) : NW'(rsh_re);
    rem_im_nx = ge_im ? NW'(rsh_im - RW'(den)) : NW'(rsh_im);
    dvd_re_nx = {dvd_re[D-2:0], ge_re};
    dvd_im_nx = {dvd_im[D-2:0], ge_im};
  end

`ifdef DIV_FIXED_COMPLEX_ROUND_EN
  assign rnd_re = {rem_re_nx, 1'b0} >= RW'(den);
  assign rnd_im = {rem_im_nx, 1'b0} >= RW'(den);
`else
  assign rnd_re = 1'b0;
  assign rnd_im = 1'b0;
`endif

  assign mq_re     = {1'b0, dvd_re_nx} + (D+1)'(rnd_re);
  assign mq_im     = {1'b0, dvd_im_nx} + (D+1)'(rnd_im);
  assign res_re    = saturate(mq_re, sgn_re);
  assign res_im    = saturate(mq_im, sgn_im);
  assign last_step = (cnt == CW'(D - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: state_nx = S_DIV;
      S_DIV:  if (last_step) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; the result is latched on the final DIV edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar          <= '0;
      ai          <= '0;
      br          <= '0;
      bi          <= '0;
      dvd_re      <= '0;
      dvd_im      <= '0;
      rem_re      <= '0;
      rem_im      <= '0;
      den         <= '0;
      sgn_re      <= 1'b0;
      sgn_im      <= 1'b0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      y_Re        <= '0;
      y_Im        <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_nx == S_LOAD) || (state_nx == S_DIV);
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ar <= a_Re;
            ai <= a_Im;
            br <= b_Re;
            bi <= b_Im;
          end
        end
        S_LOAD: begin
          dvd_re <= {mag_re, {QF{1'b0}}};
          dvd_im <= {mag_im, {QF{1'b0}}};
          den    <= den_c;
          sgn_re <= num_re[NW-1];
          sgn_im <= num_im[NW-1];
          rem_re <= '0;
          rem_im <= '0;
          cnt    <= '0;
        end
        S_DIV: begin
          rem_re <= rem_re_nx;
          rem_im <= rem_im_nx;
          dvd_re <= dvd_re_nx;
          dvd_im <= dvd_im_nx;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            done <= 1'b1;
            if (den == '0) begin
              y_Re        <= '0;
              y_Im        <= '0;
              overflow    <= 1'b0;
              div_by_zero <= 1'b1;
            end else begin
              y_Re        <= res_re[W-1:0];
              y_Im        <= res_im[W-1:0];
              overflow    <= res_re[W] | res_im[W];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_fixed_complex_seq.sv
// Bench for div_fixed_complex_seq: directed, handshake and randomized checks against
// an integer-arithmetic reference of the complex quotient.
module tb_div_fixed_complex_seq;
  localparam int W  = 6;
  localparam int QF = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic signed [W-1:0] a_re, a_im, b_re, b_im;
  logic busy, done;
  logic signed [W-1:0] y_re, y_im;
  logic overflow, div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_fixed_complex_seq #(.QI(3), .QF(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_Re(a_re), .a_Im(a_im), .b_Re(b_re), .b_Im(b_im),
    .busy(busy), .done(done), .y_Re(y_re), .y_Im(y_im),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  // Reference for one component: |n|*2^QF/den, optional rounding, sign, clamp
  function automatic void ref_comp(input int n, input int den, output int y, output bit sat);
    int an, mag;
    an  = (n < 0) ? -n : n;
    mag = (an * (1 << QF)) / den;
`ifdef DIV_FIXED_COMPLEX_ROUND_EN
    if (2 * ((an * (1 << QF)) % den) >= den) mag = mag + 1;
`endif
    sat = 1'b0;
    if (n >= 0) begin
      if (mag > 31) begin mag = 31; sat = 1'b1; end
      y = mag;
    end else begin
      if (mag > 32) begin mag = 32; sat = 1'b1; end
      y = -mag;
    end
  endfunction

  function automatic void ref_div(input int ar, input int ai, input int br, input int bi,
                                  output int yr, output int yi, output bit ov, output bit dz);
    int nr, ni, den;
    bit sr, si;
    nr  = ar * br + ai * bi;
    ni  = ai * br - ar * bi;
    den = br * br + bi * bi;
    if (den == 0) begin
      yr = 0; yi = 0; ov = 1'b0; dz = 1'b1;
    end else begin
      ref_comp(nr, den, yr, sr);
      ref_comp(ni, den, yi, si);
      ov = sr | si;
      dz = 1'b0;
    end
  endfunction

  // Waits one edge to be sure of IDLE, then presents operands and start for one edge.
  // Returns sampled just after the accepting edge (cycle 1).
  task automatic launch(input logic signed [W-1:0] ar, ai, br, bi);
    @(posedge clk);
    @(negedge clk);
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle index (start edge = cycle 0) at which done is seen, or -1 on timeout
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 2; c <= 60; c++) begin
      @(posedge clk); #1;
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    #3;
    checks++;
    if ({busy, done, y_re, y_im, overflow, div_by_zero} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b y=(%0d,%0d) ov=%b dz=%b expected all 0",
               busy, done, y_re, y_im, overflow, div_by_zero);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_identity_timing;
    logic exp_busy, exp_done;
    launch(6'sd8, 6'sd0, 6'sd8, 6'sd0);
    for (int c = 1; c <= 19; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      exp_busy = (c >= 1) && (c <= 16);
      exp_done = (c == 17);
      checks++;
      if (busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL identity_timing cycle %0d got busy=%b done=%b expected busy=%b done=%b",
                 c, busy, done, exp_busy, exp_done);
      end
      if (c == 17) begin
        checks++;
        if (y_re !== 6'sd8 || y_im !== 6'sd0 || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
          failures++;
          $display("FAIL identity_result got y=(%0d,%0d) ov=%b dz=%b expected (8,0) ov=0 dz=0",
                   y_re, y_im, overflow, div_by_zero);
        end
      end
    end
  endtask

  task automatic test_directed;
    int t_ar [7] = '{8, 8, 8, -8, 31, -32, 5};
    int t_ai [7] = '{8, 0, 0, 0, 0, 0, -7};
    int t_br [7] = '{0, 24, 24, 24, 1, 1, 0};
    int t_bi [7] = '{8, 0, 0, 0, 0, 0, 0};
`ifdef DIV_FIXED_COMPLEX_ROUND_EN
    int e_yr [7] = '{8, 3, 3, -3, 31, -32, 0};
`else
    int e_yr [7] = '{8, 2, 2, -2, 31, -32, 0};
`endif
    int e_yi [7] = '{-8, 0, 0, 0, 0, 0, 0};
    bit e_ov [7] = '{0, 0, 0, 0, 1, 1, 0};
    bit e_dz [7] = '{0, 0, 0, 0, 0, 0, 1};
    int lat;
    for (int i = 0; i < 7; i++) begin
      launch(6'(t_ar[i]), 6'(t_ai[i]), 6'(t_br[i]), 6'(t_bi[i]));
      wait_done(lat);
      checks++;
      if (lat !== 17) begin
        failures++;
        $display("FAIL directed_latency vec %0d got %0d expected 17", i, lat);
      end
      checks++;
      if (y_re !== 6'(e_yr[i]) || y_im !== 6'(e_yi[i]) ||
          overflow !== e_ov[i] || div_by_zero !== e_dz[i]) begin
        failures++;
        $display("FAIL directed_result vec %0d got y=(%0d,%0d) ov=%b dz=%b expected (%0d,%0d) ov=%b dz=%b",
                 i, y_re, y_im, overflow, div_by_zero, e_yr[i], e_yi[i], e_ov[i], e_dz[i]);
      end
    end
  endtask

  task automatic test_random;
    int ar, ai, br, bi, eyr, eyi, lat;
    bit eov, edz;
    for (int n = 0; n < 150; n++) begin
      ar = int'($signed(6'($urandom)));
      ai = int'($signed(6'($urandom)));
      br = int'($signed(6'($urandom)));
      bi = int'($signed(6'($urandom)));
      if (n % 25 == 0) begin br = 0; bi = 0; end
      ref_div(ar, ai, br, bi, eyr, eyi, eov, edz);
      launch(6'(ar), 6'(ai), 6'(br), 6'(bi));
      wait_done(lat);
      checks++;
      if (lat !== 17 || y_re !== 6'(eyr) || y_im !== 6'(eyi) ||
          overflow !== eov || div_by_zero !== edz) begin
        failures++;
        $display("FAIL random a=(%0d,%0d) b=(%0d,%0d) got lat=%0d y=(%0d,%0d) ov=%b dz=%b expected lat=17 y=(%0d,%0d) ov=%b dz=%b",
                 ar, ai, br, bi, lat, y_re, y_im, overflow, div_by_zero, eyr, eyi, eov, edz);
      end
    end
  endtask

  task automatic test_start_during_busy;
    int ndone, first, eyr, eyi, gyr, gyi;
    bit eov, edz;
    ref_div(12, -5, 3, 9, eyr, eyi, eov, edz);
    launch(6'sd12, -6'sd5, 6'sd3, 6'sd9);
    ndone = 0; first = -1; gyr = 0; gyi = 0;
    for (int c = 2; c <= 45; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first < 0) begin first = c; gyr = int'(y_re); gyi = int'(y_im); end
      end
      if (c >= 5 && c <= 10) begin
        start = 1'b1; a_re = -6'sd20; a_im = 6'sd17; b_re = 6'sd1; b_im = -6'sd2;
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (ndone !== 1 || first !== 17) begin
      failures++;
      $display("FAIL busy_start_done got count=%0d first=%0d expected count=1 first=17", ndone, first);
    end
    checks++;
    if (gyr !== eyr || gyi !== eyi) begin
      failures++;
      $display("FAIL busy_start_result got (%0d,%0d) expected (%0d,%0d)", gyr, gyi, eyr, eyi);
    end
  endtask

  task automatic test_back_to_back;
    int lat, eyr, eyi;
    bit eov, edz;
    launch(6'sd16, 6'sd0, 6'sd8, 6'sd0);
    wait_done(lat);
    checks++;
    if (lat !== 17 || y_re !== 6'sd16) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d y_re=%0d expected lat=17 y_re=16", lat, y_re);
    end
    ref_div(-9, 4, 4, -4, eyr, eyi, eov, edz);
    a_re = -6'sd9; a_im = 6'sd4; b_re = 6'sd4; b_im = -6'sd4;
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || y_re !== 6'sd16) begin
      failures++;
      $display("FAIL b2b_done_cycle_start got busy=%b done=%b y_re=%0d expected busy=0 done=0 y_re=16",
               busy, done, y_re);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle_accept got busy=%b expected 1", busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== 17 || y_re !== 6'(eyr) || y_im !== 6'(eyi) || overflow !== eov) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d y=(%0d,%0d) ov=%b expected lat=17 y=(%0d,%0d) ov=%b",
               lat, y_re, y_im, overflow, eyr, eyi, eov);
    end
  endtask

  task automatic test_reset_mid;
    int ndone, lat;
    launch(6'sd31, 6'sd0, 6'sd1, 6'sd0);
    for (int c = 2; c <= 8; c++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, y_re, y_im, overflow, div_by_zero} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got busy=%b done=%b y=(%0d,%0d) ov=%b dz=%b expected all 0",
               busy, done, y_re, y_im, overflow, div_by_zero);
    end
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL midreset_no_done got %0d active cycles expected 0", ndone);
    end
    launch(6'sd8, 6'sd8, 6'sd0, 6'sd8);
    wait_done(lat);
    checks++;
    if (lat !== 17 || y_re !== 6'sd8 || y_im !== -6'sd8 || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL midreset_recover got lat=%0d y=(%0d,%0d) ov=%b dz=%b expected lat=17 y=(8,-8) ov=0 dz=0",
               lat, y_re, y_im, overflow, div_by_zero);
    end
  endtask

  initial begin
    test_reset();
    test_identity_timing();
    test_directed();
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
